mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single data-memory port between the pipeline's memory stage (CPU requester) and the I/O loader that streams data in and out while `startIO` is active (IO requester). The CPU has fixed priority. A starvation counter forces one IO beat after a bounded wait. One-cycle read latency is tracked so returned data is steered to the requester that issued the read. The block sits between the Execute–Memory pipeline register and the `memory` data port. When it withholds a grant, its `cpuStall` output is OR-ed into the hazard unit's stall/flush logic.

## Interface
- `WIDTH`, 36: data and address width.
- `STARVELIMIT`, 4: consecutive denied IO cycles before IO is forced; legal range 1..15.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; one clock domain, reset polarity and synchronicity fixed.
- `cpuReq`  in  1  memory-stage access valid this cycle.
- `cpuWe`  in  1  CPU write (1) / read (0).
- `cpuAddr`, `cpuWData`  in  WIDTH  CPU address and write data.
- `cpuRData`  out  WIDTH  read data, valid the cycle after a granted CPU read.
- `cpuStall`  out  1  CPU request present but not granted this cycle.
- `ioReq`, `ioWe`  in  1  IO request valid, and IO write/read.
- `ioAddr`, `ioWData`  in  WIDTH  IO address and write data.
- `ioGnt`  out  1  IO beat accepted this cycle.
- `ioRValid`  out  1  `ioRData` valid (registered).
- `ioRData`  out  WIDTH  IO read data.
- `memWe`  out  1  memory write enable.
- `memAddr`, `memWData`  out  WIDTH  memory address and write data.
- `memRData`  in  WIDTH  memory read data; one-cycle latency.
- `forcedIO`  out  1  current IO grant is a starvation-forced grant (debug/coverage).

## Operation
- Grant is decided combinationally each cycle from the requests, `starveCnt` and the state. At most one requester is granted.
- States:
  - CPU_PRIO: normal operation.
    - `cpuReq=1` and `starveCnt<STARVELIMIT`: grant CPU.
    - Otherwise, `ioReq=1`: grant IO.
    - A grant to IO while `cpuReq=1` is forced: assert `forcedIO` and move to IO_FORCE.
  - IO_FORCE: lasts exactly one cycle and is a cooldown.
    - `cpuReq=1`: grant CPU unconditionally.
    - Otherwise, `ioReq=1`: grant IO.
    - Always return to CPU_PRIO.
- `starveCnt`, 4 bits:
  - Increments on `ioReq=1` with no IO grant, saturating at `STARVELIMIT`.
  - Clears to 0 on any IO grant or when `ioReq=0`.
- Memory port mux:
  - CPU granted: drive the `cpu*` fields onto the memory port.
  - IO granted: drive the `io*` fields onto the memory port.
  - No grant: `memWe=0`, `memAddr=0`, `memWData=0`.
  - `memWe` is never 1 without a grant.
- `cpuStall = cpuReq & ~cpuGnt`.
- Read return:
  - Register `rdOwner` = {none, cpu, io} for a granted read.
  - A granted write sets `rdOwner`=none.
  - When `rdOwner`=io: `ioRValid=1` and `ioRData=memRData`, captured the same cycle the data arrives.
  - `cpuRData` is always `memRData`, passed through combinationally. The CPU pipeline register provides its own qualification.
- The IO requester must hold `ioReq`, `ioWe`, `ioAddr` and `ioWData` stable until `ioGnt`.

## Timing
- Grant latency: 0 cycles (same cycle as request).
- Read data: `memRData` at cycle N+1 for a grant at cycle N.
- `ioRValid` is asserted during cycle N+1 only, one cycle wide per read beat.
- Worst-case IO wait under continuous `cpuReq`: `STARVELIMIT` denied cycles, then a forced grant. The pattern is periodic with period `STARVELIMIT+1`.
- Worst-case extra CPU stall: 1 cycle per forced IO grant. Two consecutive forced grants are impossible because of IO_FORCE.
- Reset low, asynchronous and immediate:
  - State is CPU_PRIO.
  - `starveCnt=0`, `rdOwner`=none, `ioRValid=0`, `forcedIO=0`.
  - A read in flight is dropped, with no `ioRValid` after release.
  - While reset is low, all grants are 0, `memWe=0` and `cpuStall=cpuReq`.
- Simultaneous `cpuReq` and `ioReq` with `starveCnt<STARVELIMIT`: CPU wins.
- `ioReq` dropped before grant: counter clears, no grant.
- Back-to-back IO reads with no CPU traffic: `ioRValid` high every cycle, with the data in order.

## Test plan
- Reset release, then CPU write of 0x123 to address 5 followed by a read of 5: `memWe=1` in cycle 0, `cpuStall=0`, `cpuRData=0x123` at cycle 2.
- `cpuReq` continuously 1, `ioReq` held with a read of address 7 (mem[7]=0xABC), `STARVELIMIT=4`:
  - `ioGnt` first at cycle 4, with `forcedIO=1` and `cpuStall=1` only in that cycle.
  - `ioRValid=1` with `ioRData=0xABC` at cycle 5.
  - The next forced grant is at cycle 9.
- IO-only burst of 8 reads to addresses 0..7, `cpuReq=0`: `ioGnt` every cycle, `ioRValid` from cycles 1..8 in address order, `starveCnt` stays 0.
- Simultaneous requests with `starveCnt=0`: CPU granted. `ioReq` dropped after 2 denied cycles: no forced grant, counter back to 0.
- Forced IO read granted, then `reset` asserted mid-cycle before data returns: `ioRValid` stays 0 through release; first grant after release goes to the CPU.
- IO write during a forced grant, then the CPU reads the same address: the CPU sees the IO-written value.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the CPU requester, IO requester and data-memory port signals
//   shared between the memory-stage arbiter and its surroundings.
//   slave  : the arbiter's view (requests and memRData in, grants and mux out)
//   master : the requesters'/memory's view (opposite directions)
interface mem_port_arbiter_if #(
    parameter int WIDTH = 36
);
    logic             cpuReq;
    logic             cpuWe;
    logic [WIDTH-1:0] cpuAddr;
    logic [WIDTH-1:0] cpuWData;
    logic [WIDTH-1:0] cpuRData;
    logic             cpuStall;

    logic             ioReq;
    logic             ioWe;
    logic [WIDTH-1:0] ioAddr;
    logic [WIDTH-1:0] ioWData;
    logic             ioGnt;
    logic             ioRValid;
    logic [WIDTH-1:0] ioRData;

    logic             memWe;
    logic [WIDTH-1:0] memAddr;
    logic [WIDTH-1:0] memWData;
    logic [WIDTH-1:0] memRData;

    logic             forcedIO;

    modport slave (
        input  cpuReq, cpuWe, cpuAddr, cpuWData,
        input  ioReq, ioWe, ioAddr, ioWData,
        input  memRData,
        output cpuRData, cpuStall,
        output ioGnt, ioRValid, ioRData,
        output memWe, memAddr, memWData,
        output forcedIO
    );

    modport master (
        output cpuReq, cpuWe, cpuAddr, cpuWData,
        output ioReq, ioWe, ioAddr, ioWData,
        output memRData,
        input  cpuRData, cpuStall,
        input  ioGnt, ioRValid, ioRData,
        input  memWe, memAddr, memWData,
        input  forcedIO
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-memory port between the CPU memory stage (fixed
//   priority) and the IO loader. A starvation counter forces one IO beat after
//   STARVELIMIT consecutive denied cycles; the cycle after a forced beat the
//   CPU always wins. Read ownership is tracked for the one-cycle memory
//   latency so returned data reaches the requester that issued the read.
// Ports
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_port_arbiter_if.slave (CPU, IO and memory port signals)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CPU_PRIO | normal; CPU wins unless the IO starvation limit is reached
// IO_FORCE | one-cycle cooldown after a forced IO beat; CPU always wins
module mem_port_arbiter #(
    parameter int WIDTH       = 36,
    parameter int STARVELIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [0:0] CPU_PRIO = 1'b0;
    localparam logic [0:0] IO_FORCE = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_IO   = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVELIMIT);

    logic [0:0] state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic [1:0] rd_owner_q, rd_owner_d;

    logic cpu_gnt;
    logic io_gnt;
    logic forced;

    // Grants are gated by reset so nothing reaches memory while held in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        io_gnt  = 1'b0;
        if (reset) begin
            if (bus.cpuReq && (state_q == IO_FORCE || starve_cnt_q < LIMIT)) begin
                cpu_gnt = 1'b1;
            end else if (bus.ioReq) begin
                io_gnt = 1'b1;
            end
        end
    end

    // An IO grant while the CPU is asking can only come from starvation.
    assign forced = io_gnt & bus.cpuReq;

    always_comb begin
        state_d = forced ? IO_FORCE : CPU_PRIO;

        starve_cnt_d = 4'd0;
        if (bus.ioReq && !io_gnt) begin
            starve_cnt_d = (starve_cnt_q < LIMIT) ? starve_cnt_q + 4'd1 : starve_cnt_q;
        end

        rd_owner_d = OWN_NONE;
        if (cpu_gnt && !bus.cpuWe) begin
            rd_owner_d = OWN_CPU;
        end else if (io_gnt && !bus.ioWe) begin
            rd_owner_d = OWN_IO;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= CPU_PRIO;
            starve_cnt_q <= 4'd0;
            rd_owner_q   <= OWN_NONE;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    always_comb begin
        bus.memWe    = 1'b0;
        bus.memAddr  = '0;
        bus.memWData = '0;
        if (cpu_gnt) begin
            bus.memWe    = bus.cpuWe;
            bus.memAddr  = bus.cpuAddr;
            bus.memWData = bus.cpuWData;
        end else if (io_gnt) begin
            bus.memWe    = bus.ioWe;
            bus.memAddr  = bus.ioAddr;
            bus.memWData = bus.ioWData;
        end
    end

    assign bus.cpuStall = bus.cpuReq & ~cpu_gnt;
    assign bus.ioGnt    = io_gnt;
    assign bus.forcedIO = forced;

    // CPU data is unqualified; the pipeline register knows when it asked.
    assign bus.cpuRData = bus.memRData;
    assign bus.ioRValid = (rd_owner_q == OWN_IO);
    assign bus.ioRData  = (rd_owner_q == OWN_IO) ? bus.memRData : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int WIDTH = 36;
    localparam int LIMIT = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mem_port_arbiter #(.WIDTH(WIDTH), .STARVELIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // memory behind the port: registered read, one-cycle latency
    logic [WIDTH-1:0] mem     [256];
    logic [WIDTH-1:0] ref_mem [256];
    always @(posedge clock) begin
        if (bus.memWe) mem[bus.memAddr[7:0]] <= bus.memWData;
        bus.memRData <= mem[bus.memAddr[7:0]];
    end

    typedef struct {
        int               due;
        logic [WIDTH-1:0] data;
    } rd_t;
    rd_t ioq[$];
    rd_t cpuq[$];

    // reference model: cycles IO has waited, and whether last beat was forced
    int m_waited = 0;
    bit m_cool = 1'b0;
    bit rst_on_forced = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // monitor: read returns
    always @(posedge clock) begin : monitor
        bit exp_v;
        #2;
        exp_v = (ioq.size() > 0) && (ioq[0].due == cyc);
        chk("ioRValid", {63'd0, bus.ioRValid}, {63'd0, exp_v});
        if (exp_v) begin
            if (bus.ioRValid) chk("ioRData", 64'(bus.ioRData), 64'(ioq[0].data));
            void'(ioq.pop_front());
        end
        if (cpuq.size() > 0 && cpuq[0].due == cyc) begin
            chk("cpuRData", 64'(bus.cpuRData), 64'(cpuq[0].data));
            void'(cpuq.pop_front());
        end
    end

    // one cycle: drive at negedge, check combinational response, advance model
    task automatic tick(input bit cR, input bit cW, input logic [WIDTH-1:0] cA,
                        input logic [WIDTH-1:0] cD, input bit iR, input bit iW,
                        input logic [WIDTH-1:0] iA, input logic [WIDTH-1:0] iD,
                        output bit g_io);
        bit e_cpu, e_io, e_forced, e_we;
        logic [WIDTH-1:0] e_addr, e_wd;
        bus.cpuReq = cR; bus.cpuWe = cW; bus.cpuAddr = cA; bus.cpuWData = cD;
        bus.ioReq  = iR; bus.ioWe  = iW; bus.ioAddr  = iA; bus.ioWData  = iD;
        #1;
        e_cpu = 1'b0;
        e_io  = 1'b0;
        if (reset) begin
            e_cpu = cR && (m_cool || m_waited < LIMIT);
            e_io  = !e_cpu && iR;
        end
        e_forced = e_io && cR;
        e_we   = e_cpu ? cW : (e_io ? iW : 1'b0);
        e_addr = e_cpu ? cA : (e_io ? iA : '0);
        e_wd   = e_cpu ? cD : (e_io ? iD : '0);
        chk("ioGnt",    {63'd0, bus.ioGnt},    {63'd0, e_io});
        chk("cpuStall", {63'd0, bus.cpuStall}, {63'd0, cR && !e_cpu});
        chk("forcedIO", {63'd0, bus.forcedIO}, {63'd0, e_forced});
        chk("memWe",    {63'd0, bus.memWe},    {63'd0, e_we});
        chk("memAddr",  64'(bus.memAddr),  64'(e_addr));
        chk("memWData", 64'(bus.memWData), 64'(e_wd));
        g_io = bus.ioGnt;
        if (e_cpu) begin
            if (cW) ref_mem[cA[7:0]] = cD;
            else cpuq.push_back('{due: cyc + 1, data: ref_mem[cA[7:0]]});
        end
        if (e_io) begin
            if (iW) ref_mem[iA[7:0]] = iD;
            else ioq.push_back('{due: cyc + 1, data: ref_mem[iA[7:0]]});
        end
        if (reset) begin
            m_waited = (iR && !e_io) ? ((m_waited < LIMIT) ? m_waited + 1 : m_waited) : 0;
            m_cool   = e_forced;
        end else begin
            m_waited = 0;
            m_cool   = 1'b0;
        end
        if (rst_on_forced && e_forced) begin
            #2;
            reset = 1'b0;
            ioq.delete();
            cpuq.delete();
            m_waited = 0;
            m_cool   = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic idle();
        bit g;
        tick(0, 0, '0, '0, 0, 0, '0, '0, g);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit g;
        int gnts[$];
        int cnt;
        bit io_act, io_we, seen;
        logic [WIDTH-1:0] io_a, io_d;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 36'h100 + 36'(i * 17);
            ref_mem[i] = mem[i];
        end
        mem[7] = 36'hABC;
        ref_mem[7] = 36'hABC;

        @(negedge clock);
        // held in reset: no grants, stall mirrors the CPU request
        tick(1, 1, 36'd5, 36'h111, 1, 0, 36'd3, '0, g);
        reset = 1'b1;

        // CPU write then read back
        tick(1, 1, 36'd5, 36'h123, 0, 0, '0, '0, g);
        tick(1, 0, 36'd5, '0, 0, 0, '0, '0, g);
        idle();

        // continuous CPU traffic against a held IO read of address 7
        gnts.delete();
        for (int k = 0; k < 10; k++) begin
            tick(1, 0, 36'(20 + k), '0, 1, 0, 36'd7, '0, g);
            if (g) gnts.push_back(k);
        end
        chk("starve_grant_count", 64'(gnts.size()), 64'd2);
        if (gnts.size() == 2) begin
            chk("starve_first_grant",  64'(gnts[0]), 64'd4);
            chk("starve_second_grant", 64'(gnts[1]), 64'd9);
        end
        idle();

        // IO-only read burst
        cnt = 0;
        for (int a = 0; a < 8; a++) begin
            tick(0, 0, '0, '0, 1, 0, 36'(a), '0, g);
            cnt += int'(g);
        end
        chk("burst_grants", 64'(cnt), 64'd8);
        idle();

        // simultaneous requests, IO gives up after two denials
        tick(1, 0, 36'd1, '0, 1, 0, 36'd2, '0, g);
        tick(1, 0, 36'd1, '0, 1, 0, 36'd2, '0, g);
        tick(1, 0, 36'd1, '0, 0, 0, '0, '0, g);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 36'd1, '0, 1, 0, 36'd2, '0, g);
            cnt += int'(g);
        end
        chk("no_grant_after_drop", 64'(cnt), 64'd0);
        idle();

        // forced IO read, reset asserted before its data returns
        rst_on_forced = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick(1, 0, 36'd3, '0, 1, 0, 36'd7, '0, g);
            seen = g;
        end
        rst_on_forced = 1'b0;
        chk("forced_before_reset", {63'd0, seen}, 64'd1);
        tick(1, 0, 36'd3, '0, 1, 0, 36'd7, '0, g);
        reset = 1'b1;
        tick(1, 0, 36'd3, '0, 1, 0, 36'd7, '0, g);
        chk("post_reset_first_gnt_cpu", {63'd0, g}, 64'd0);
        idle();

        // IO write lands during a forced grant, CPU reads it back
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick(1, 0, 36'd4, '0, 1, 1, 36'd9, 36'h5A5, g);
            seen = g;
        end
        chk("forced_io_write", {63'd0, seen}, 64'd1);
        tick(1, 0, 36'd9, '0, 0, 0, '0, '0, g);
        idle();
        chk("io_write_visible", 64'(ref_mem[9]), 64'h5A5);

        // randomized traffic; IO holds its beat until granted (rare drops)
        io_act = 1'b0;
        io_we = 1'b0;
        io_a = '0;
        io_d = '0;
        for (int n = 0; n < 600; n++) begin
            if (!io_act && $urandom_range(9, 0) < 6) begin
                io_act = 1'b1;
                io_we  = 1'($urandom_range(1, 0));
                io_a   = 36'($urandom_range(15, 0));
                io_d   = {4'($urandom_range(15, 0)), 32'($urandom)};
            end
            tick(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 36'($urandom_range(15, 0)), {4'($urandom_range(15, 0)), 32'($urandom)},
                 io_act, io_we, io_a, io_d, g);
            if (g || $urandom_range(15, 0) == 0) io_act = 1'b0;
        end
        repeat (3) idle();

        chk("io_queue_drained",  64'(ioq.size()),  64'd0);
        chk("cpu_queue_drained", 64'(cpuq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
